// File: rtl/id_ex_queue_if.sv
// id_ex_queue_if: decode-to-execute handshake and head-field bus.
// master = decode/execute side, slave = the queue itself.
interface id_ex_queue_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 8,
  parameter int REG_WIDTH  = 4,
  parameter int IMM_WIDTH  = 8,
  parameter int CV_WIDTH   = 11,
  parameter int DEPTH      = 2,
  parameter int CNT_WIDTH  = 16
);
  localparam int OPC_WIDTH   = DATA_WIDTH - 3 * REG_WIDTH;
  localparam int COUNT_WIDTH = $clog2(DEPTH + 1);

  // control and input side
  logic                   flush_i;
  logic                   in_valid_i;
  logic                   in_ready_o;
  logic [ADDR_WIDTH-1:0]  pc_i;
  logic [DATA_WIDTH-1:0]  instr_i;
  logic [CV_WIDTH-1:0]    ctrl_i;

  // head (execute) side
  logic                   out_valid_o;
  logic                   out_ready_i;
  logic [ADDR_WIDTH-1:0]  pc_o;
  logic [OPC_WIDTH-1:0]   opcode_o;
  logic [REG_WIDTH-1:0]   rs_o;
  logic [REG_WIDTH-1:0]   rt_o;
  logic [REG_WIDTH-1:0]   rd_o;
  logic [IMM_WIDTH-1:0]   imm_o;
  logic [CV_WIDTH-1:0]    ctrl_o;

  // status
  logic [COUNT_WIDTH-1:0] count_o;
  logic [CNT_WIDTH-1:0]   stall_cnt_o;
  logic [CNT_WIDTH-1:0]   flush_cnt_o;

  modport master (
    output flush_i, in_valid_i, pc_i, instr_i, ctrl_i, out_ready_i,
    input  in_ready_o, out_valid_o, pc_o, opcode_o, rs_o, rt_o, rd_o,
    input  imm_o, ctrl_o, count_o, stall_cnt_o, flush_cnt_o
  );

  modport slave (
    input  flush_i, in_valid_i, pc_i, instr_i, ctrl_i, out_ready_i,
    output in_ready_o, out_valid_o, pc_o, opcode_o, rs_o, rt_o, rd_o,
    output imm_o, ctrl_o, count_o, stall_cnt_o, flush_cnt_o
  );
endinterface

// File: rtl/id_ex_queue.sv
// id_ex_queue: DEPTH-entry valid/ready buffer between decode and execute.
// Stores PC, raw instruction and control vector in a circular buffer and
// presents the sliced fields of the oldest entry. Empty queue drives an
// all-zero bubble. Flush and reset empty the queue at the next edge.
// Optional perf counters are built when ID_EX_QUEUE_PERF_EN is defined;
// otherwise stall_cnt_o and flush_cnt_o are tied to zero.
module id_ex_queue #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 8,
  parameter int REG_WIDTH  = 4,
  parameter int IMM_WIDTH  = 8,
  parameter int CV_WIDTH   = 11,
  parameter int DEPTH      = 2,
  parameter int CNT_WIDTH  = 16
) (
  input  logic        clk,
  input  logic        rst,
  id_ex_queue_if.slave bus
);
  localparam int PTR_WIDTH   = $clog2(DEPTH);
  localparam int COUNT_WIDTH = $clog2(DEPTH + 1);
  localparam int OPC_WIDTH   = DATA_WIDTH - 3 * REG_WIDTH;
  localparam logic [COUNT_WIDTH-1:0] FULL_COUNT = COUNT_WIDTH'(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
    $error("id_ex_queue: DEPTH must be a power of 2 and at least 2");
  end

  logic [ADDR_WIDTH-1:0]  pc_mem    [DEPTH];
  logic [DATA_WIDTH-1:0]  instr_mem [DEPTH];
  logic [CV_WIDTH-1:0]    ctrl_mem  [DEPTH];

  logic [PTR_WIDTH-1:0]   wr_ptr;
  logic [PTR_WIDTH-1:0]   rd_ptr;
  logic [COUNT_WIDTH-1:0] count;

  logic                   in_ready;
  logic                   out_valid;
  logic                   push;
  logic                   pop;

  logic [ADDR_WIDTH-1:0]  head_pc;
  logic [DATA_WIDTH-1:0]  head_instr;
  logic [CV_WIDTH-1:0]    head_ctrl;

  // ready/valid depend only on registered occupancy
  assign in_ready  = (count < FULL_COUNT);
  assign out_valid = (count != '0);
  assign push      = bus.in_valid_i & in_ready  & ~bus.flush_i;
  assign pop       = out_valid & bus.out_ready_i & ~bus.flush_i;

  // pointer and occupancy update; reset dominates flush
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (bus.flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + COUNT_WIDTH'(push) - COUNT_WIDTH'(pop);
    end
  end

  // entry storage; contents are only observable while counted as valid
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]    <= bus.pc_i;
      instr_mem[wr_ptr] <= bus.instr_i;
      ctrl_mem[wr_ptr]  <= bus.ctrl_i;
    end
  end

  // head selection, zeroed when empty so the bubble carries no enables
  always_comb begin
    head_pc    = '0;
    head_instr = '0;
    head_ctrl  = '0;
    if (out_valid) begin
      head_pc    = pc_mem[rd_ptr];
      head_instr = instr_mem[rd_ptr];
      head_ctrl  = ctrl_mem[rd_ptr];
    end
  end

  assign bus.in_ready_o  = in_ready;
  assign bus.out_valid_o = out_valid;
  assign bus.count_o     = count;
  assign bus.pc_o        = head_pc;
  assign bus.ctrl_o      = head_ctrl;
  assign bus.opcode_o    = head_instr[DATA_WIDTH-1:3*REG_WIDTH];
  assign bus.rs_o        = head_instr[3*REG_WIDTH-1:2*REG_WIDTH];
  assign bus.rt_o        = head_instr[2*REG_WIDTH-1:REG_WIDTH];
  assign bus.rd_o        = head_instr[REG_WIDTH-1:0];
  assign bus.imm_o       = head_instr[IMM_WIDTH-1:0];

`ifdef ID_EX_QUEUE_PERF_EN
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  logic                 stall_event;
  logic [CNT_WIDTH-1:0] stall_cnt;
  logic [CNT_WIDTH-1:0] flush_cnt;
  logic [CNT_WIDTH:0]   flush_sum;

  assign stall_event = bus.in_valid_i & ~in_ready & ~bus.flush_i;
  assign flush_sum   = {1'b0, flush_cnt} + (CNT_WIDTH + 1)'(count);

  // saturating perf counters, cleared only by reset
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_event && stall_cnt != CNT_MAX)
        stall_cnt <= stall_cnt + CNT_WIDTH'(1);
      if (bus.flush_i)
        flush_cnt <= flush_sum[CNT_WIDTH] ? CNT_MAX : flush_sum[CNT_WIDTH-1:0];
    end
  end

  assign bus.stall_cnt_o = stall_cnt;
  assign bus.flush_cnt_o = flush_cnt;
`else
  assign bus.stall_cnt_o = '0;
  assign bus.flush_cnt_o = '0;
`endif

endmodule
